// File: rtl/s_box_if.sv
// SubBytes lookup bus between the round/key-expansion initiator and the
// S-box responder: one request column in, one substituted column out.
interface s_box_if;
  logic       rd_en;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] addr2;
  logic [7:0] addr3;
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic [7:0] dout2;
  logic [7:0] dout3;
  logic       done;
  logic [1:0] beat;

  modport master (
    output rd_en, addr0, addr1, addr2, addr3,
    input  dout0, dout1, dout2, dout3, done, beat
  );

  modport slave (
    input  rd_en, addr0, addr1, addr2, addr3,
    output dout0, dout1, dout2, dout3, done, beat
  );
endinterface

// File: rtl/s_box.sv
// AES forward S-box responder: four independent lanes, LATENCY-deep
// pipeline (1 or 2), registered outputs, response counter in beat.
module s_box #(
  parameter int unsigned LATENCY = 1
) (
  input logic    clk,
  input logic    rst,
  s_box_if.slave bus
);

  if (!(LATENCY inside {1, 2})) begin : g_bad_latency
    $error("s_box: LATENCY must be 1 or 2");
  end

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [3:0][7:0]               a_in;
  logic [3:0][7:0]               s_in;
  logic [LATENCY-1:0]            v_q;
  logic [LATENCY-1:0]            v_nxt;
  logic [LATENCY-1:0][3:0][7:0]  d_q;
  logic [LATENCY-1:0][3:0][7:0]  d_nxt;
  logic [LATENCY:0]              v_chain;
  logic [LATENCY:0][3:0][7:0]    d_chain;
  state_t                        state_q;
  state_t                        state_d;
  logic [1:0]                    beat_q;
  logic [1:0]                    beat_d;

  assign a_in = {bus.addr3, bus.addr2, bus.addr1, bus.addr0};

  // Lookup sits in front of stage 1, so every stage carries substituted bytes.
  always_comb begin
    s_in = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      s_in[k] = sbox(a_in[k]);
    end
  end

  // Stage advance: the chain prepends the new request so stage s loads from
  // chain[s] for any LATENCY; data only moves with a valid bit, which leaves
  // the last valid column parked on dout through bubbles.
  always_comb begin
    v_chain = {v_q, bus.rd_en};
    d_chain = {d_q, s_in};
    v_nxt   = v_chain[LATENCY-1:0];
    d_nxt   = d_q;
    for (int unsigned s = 0; s < LATENCY; s++) begin
      if (v_chain[s]) d_nxt[s] = d_chain[s];
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_nxt;
      d_q <= d_nxt;
    end
  end

  // IDLE/ACTIVE tracking and the response counter.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (v_nxt == '0) begin
      state_d = IDLE;
      beat_d  = '0;
    end else begin
      state_d = ACTIVE;
      if (state_q == ACTIVE && v_q[LATENCY-1]) beat_d = beat_q + 2'd1;
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.done  = v_q[LATENCY-1];
  assign bus.dout0 = d_q[LATENCY-1][0];
  assign bus.dout1 = d_q[LATENCY-1][1];
  assign bus.dout2 = d_q[LATENCY-1][2];
  assign bus.dout3 = d_q[LATENCY-1][3];
  assign bus.beat  = beat_q;

endmodule

// File: doc/s_box.md
# s_box

Responder end of the SubBytes lookup interface used by the round datapath. Each cycle the initiator asserts `rd_en` and presents four byte addresses (one state column); this block returns the four AES forward S-box substitutions on `dout0..dout3`. It flags each returned beat with `done`, which the initiator samples as its substitution-valid flag. It is shared by every round and by the key-expansion path.

## Interface
- `LATENCY`, default 1: pipeline depth, in cycles, from the `rd_en`/`addr` sampling edge to `done`/`dout` valid. Legal values are 1 and 2; any other value is a synthesis error.
- `clk`  input  1  system clock; all logic uses the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `rd_en`  input  1  lookup request, sampled at each rising edge.
- `addr0`..`addr3`  input  8 each  bytes to substitute (lanes 0–3), sampled with `rd_en`.
- `dout0`..`dout3`  output  8 each  substituted bytes; registered.
- `done`  output  1  marks `dout0..3` as valid for one request; registered.
- `beat`  output  2  count of responses returned since idle, modulo 4; registered.

## Operation
- Substitution is the standard AES forward S-box, S(x) = affine(x⁻¹ in GF(2^8)), with 0⁻¹ = 0. It may be built as a 256-entry constant ROM or as inversion logic; all four lanes must be identical and independent.
- The pipeline has `LATENCY` stages. Each stage holds a valid bit plus four bytes. Stage 1 captures `rd_en` and S(`addr`) or `addr`, depending on where the lookup logic sits. The final stage drives `done` and `dout`.
- There is no backpressure. Every edge with `rd_en`=1 produces exactly one `done`=1 cycle, exactly `LATENCY` edges later, in request order.
- A `rd_en`=0 edge inserts a bubble:
  - `done` goes to 0 at the corresponding output edge.
  - `dout0..3` keep their last valid values.
- Requests may be issued back-to-back indefinitely. Repeated identical addresses each produce a fresh `done` beat.
- `beat` state machine:
  - IDLE: no valid stage; `beat`=0.
  - ACTIVE: at least one valid stage.
  - `beat` increments modulo 4 on every edge where `done` is registered as 1, wrapping 3→0.
  - When all stages are invalid after an edge, the block returns to IDLE and `beat` clears to 0 on that edge.
- Changes to `addr` while `rd_en`=0 have no effect on any output.

## Timing
- Reset (`rst`=0, asynchronous, regardless of `clk`): `dout0..3`=8'h00, `done`=0, `beat`=0, all valid bits = 0.
- Reset release: the first `rd_en` can be sampled on the first rising edge with `rst`=1.
- Reset mid-operation: in-flight requests are discarded and no `done` is produced for them.
- `LATENCY`=1: request sampled at edge k gives `done`=1 and `dout` valid after edge k+1.
- Against the round initiator (registered `rd_en`/`addr` driven at edge k), the initiator sees the substitution-valid flag at edge k+2 when `LATENCY`=1.
- `LATENCY`=2: request at edge k gives a response after edge k+2.
- Simultaneous request and response on one edge is the normal streaming case; both are handled.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset values: hold `rst`=0 mid-clock with `rd_en`=1 → `dout0..3`=00, `done`=0, `beat`=0 immediately, before any clock edge.
- Single lookup (`LATENCY`=1): `addr`={00,01,53,ff} with `rd_en` high for one cycle → one cycle later `dout`={63,7c,ed,16}, `done`=1 for exactly one cycle, then `done`=0 with `dout` held.
- Four-column stream: columns {10,c9,7f,80}, {00,00,00,00}, {ff,ff,ff,ff}, {53,01,10,80} on consecutive cycles →
  - `dout`={ca,dd,d2,cd}, {63,63,63,63}, {16,16,16,16}, {ed,7c,ca,cd} in order;
  - `beat` reads 0,1,2,3, then clears to 0 on idle.
- Bubble: request, gap, request → `done` pattern 1,0,1 and `dout` held during the gap. Five back-to-back beats → `beat` wraps 3→0 on the fifth.
- Reset mid-stream: assert `rst` while two requests are in flight → no `done` after release; the next request returns correctly with `beat`=0.
- `LATENCY`=2: repeat the four-column stream scenario → identical data, delayed one extra cycle. Exhaustive sweep of 00–ff on all lanes matches the FIPS-197 table.
